// File: rtl/delay_line_writer.sv
// -----------------------------------------------------------------------------
// delay_line_writer
//   Write/recirculate side of one serial delay line. The line carries NCHAN
//   word-interleaved registers, LSB first, one bit per phase slot. Each slot
//   drives o_dl_gate with either the recirculated sense-amp bit or a new data
//   bit. One channel's word can be replaced per request. All other slots keep
//   recirculating.
//
//   Build option: define DLW_PARITY_EN to make the stored top bit the odd
//   parity of the lower WORD_BITS-1 data bits. In that build the top bit of
//   i_wr_data is ignored. Ports and timing are the same in both builds.
//
// Ports
//   i_clk       system clock; all state changes on the rising edge
//   i_rst       asynchronous, active-high reset
//   i_phase_en  one-clock strobe per phase slot
//   i_sync      frame mark; reloads the counters to (ch0, bit0)
//   i_dl_sa     sense-amp bit; valid while i_phase_en is high
//   i_wr_req    write request; hold it high until o_wr_ack
//   i_wr_chan   target channel; sampled when the request is accepted
//   i_wr_data   word to store; sampled when the request is accepted
//   o_wr_ack    one-clock pulse after the last bit of the word is driven
//   o_wr_err    one-clock pulse when i_sync aborts a write
//   o_busy      high while a write is armed or in progress
//   o_dl_gate   registered bit to the delay-line driver gate
//   o_phase     current channel slot counter
//   o_bit_cnt   current bit-time counter, 0..WORD_BITS-1
// -----------------------------------------------------------------------------
module delay_line_writer #(
   parameter int WORD_BITS = 26,
   parameter int NCHAN     = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_phase_en,
   input  logic                 i_sync,
   input  logic                 i_dl_sa,
   input  logic                 i_wr_req,
   input  logic [1:0]           i_wr_chan,
   input  logic [WORD_BITS-1:0] i_wr_data,
   output logic                 o_wr_ack,
   output logic                 o_wr_err,
   output logic                 o_busy,
   output logic                 o_dl_gate,
   output logic [1:0]           o_phase,
   output logic [4:0]           o_bit_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_WRITING = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [1:0] LP_PHASE_LAST = 2'(NCHAN - 1);
   localparam logic [4:0] LP_BIT_LAST   = 5'(WORD_BITS - 1);

   // Word image that is actually shifted onto the line.
   function automatic logic [WORD_BITS-1:0] f_store_word(input logic [WORD_BITS-1:0] d);
`ifdef DLW_PARITY_EN
      f_store_word = {~^d[WORD_BITS-2:0], d[WORD_BITS-2:0]};
`else
      f_store_word = d;
`endif
   endfunction

   state_t               r_state;
   logic [1:0]           r_chan;
   logic [WORD_BITS-1:0] r_sr;
   logic                 r_gate;
   logic                 r_ack;
   logic                 r_err;
   logic                 r_busy;
   logic [1:0]           r_phase;
   logic [4:0]           r_bit;

   state_t               w_state_nxt;
   logic [1:0]           w_chan_nxt;
   logic [WORD_BITS-1:0] w_sr_nxt;
   logic                 w_gate_nxt;
   logic                 w_ack_nxt;
   logic                 w_err_nxt;
   logic                 w_busy_nxt;
   logic [1:0]           w_phase_nxt;
   logic [4:0]           w_bit_nxt;
   logic                 w_slot_hit;

   // Next-state, counter and gate-bit decode.
   always_comb begin
      w_state_nxt = r_state;
      w_chan_nxt  = r_chan;
      w_sr_nxt    = r_sr;
      w_gate_nxt  = r_gate;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_phase_nxt = r_phase;
      w_bit_nxt   = r_bit;
      w_slot_hit  = i_phase_en && (r_phase == r_chan);

      // Slot counters: SYNC wins over a plain advance.
      if (i_sync) begin
         w_phase_nxt = 2'd0;
         w_bit_nxt   = 5'd0;
      end else if (i_phase_en) begin
         if (r_phase == LP_PHASE_LAST) begin
            w_phase_nxt = 2'd0;
            w_bit_nxt   = (r_bit == LP_BIT_LAST) ? 5'd0 : (r_bit + 5'd1);
         end else begin
            w_phase_nxt = r_phase + 2'd1;
         end
      end else begin
         w_phase_nxt = r_phase;
         w_bit_nxt   = r_bit;
      end

      // Every strobe recirculates unless the FSM claims the slot below.
      if (i_phase_en) begin
         w_gate_nxt = i_dl_sa;
      end else begin
         w_gate_nxt = r_gate;
      end

      case (r_state)
         ST_IDLE: begin
            if (i_wr_req) begin
               w_state_nxt = ST_ARMED;
               w_chan_nxt  = i_wr_chan;
               w_sr_nxt    = f_store_word(i_wr_data);
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (i_sync) begin
               w_state_nxt = ST_IDLE;
               w_err_nxt   = 1'b1;
            end else if (w_slot_hit && (r_bit == 5'd0)) begin
               w_gate_nxt  = r_sr[0];
               w_sr_nxt    = {1'b0, r_sr[WORD_BITS-1:1]};
               w_state_nxt = ST_WRITING;
            end else begin
               w_state_nxt = ST_ARMED;
            end
         end
         ST_WRITING: begin
            if (i_sync) begin
               // Abort: whatever was already written stays on the line.
               w_state_nxt = ST_IDLE;
               w_err_nxt   = 1'b1;
            end else if (w_slot_hit) begin
               w_gate_nxt = r_sr[0];
               w_sr_nxt   = {1'b0, r_sr[WORD_BITS-1:1]};
               // BIT_CNT equals the data bit index, because the write
               // started at bit 0 of this channel.
               if (r_bit == LP_BIT_LAST) begin
                  w_state_nxt = ST_DONE;
                  w_ack_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ST_WRITING;
               end
            end else begin
               w_state_nxt = ST_WRITING;
            end
         end
         ST_DONE: begin
            // Wait for the request to drop so a held request is not re-accepted.
            if (!i_wr_req) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_WRITING);
   end

   // State, shift register, counters and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_chan  <= 2'd0;
         r_sr    <= '0;
         r_gate  <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_phase <= 2'd0;
         r_bit   <= 5'd0;
      end else begin
         r_state <= w_state_nxt;
         r_chan  <= w_chan_nxt;
         r_sr    <= w_sr_nxt;
         r_gate  <= w_gate_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_busy  <= w_busy_nxt;
         r_phase <= w_phase_nxt;
         r_bit   <= w_bit_nxt;
      end
   end

   assign o_wr_ack  = r_ack;
   assign o_wr_err  = r_err;
   assign o_busy    = r_busy;
   assign o_dl_gate = r_gate;
   assign o_phase   = r_phase;
   assign o_bit_cnt = r_bit;

endmodule

// File: tb/tb_delay_line_writer.sv
module tb_delay_line_writer;
   localparam int WB    = 26;
   localparam int NC    = 4;
   localparam int NSLOT = WB * NC;

   logic          clk = 1'b0;
   logic          rst, pe, sync, sa, req;
   logic [1:0]    chan;
   logic [WB-1:0] data;
   logic          ack, err, busy, gate;
   logic [1:0]    phase;
   logic [4:0]    bitc;

   int total = 0;
   int bad   = 0;

   // Reference model: the slot number within one revolution (bit*NC + channel),
   // a write status, and the latched word indexed directly by bit number.
   int            m_slot;
   int            m_st;       // 0 idle, 1 armed, 2 writing, 3 done
   int            m_chan;
   logic [WB-1:0] m_word;
   logic          m_gate, m_ack, m_err;
   logic          last_ack_gate;

   delay_line_writer #(.WORD_BITS(WB), .NCHAN(NC)) dut (
      .i_clk(clk), .i_rst(rst), .i_phase_en(pe), .i_sync(sync), .i_dl_sa(sa),
      .i_wr_req(req), .i_wr_chan(chan), .i_wr_data(data),
      .o_wr_ack(ack), .o_wr_err(err), .o_busy(busy), .o_dl_gate(gate),
      .o_phase(phase), .o_bit_cnt(bitc)
   );

   always #5 clk = ~clk;

   function automatic logic [WB-1:0] stored(input logic [WB-1:0] d);
`ifdef DLW_PARITY_EN
      stored = {~^d[WB-2:0], d[WB-2:0]};
`else
      stored = d;
`endif
   endfunction

   task automatic model_reset();
      m_slot = 0; m_st = 0; m_gate = 1'b0; m_ack = 1'b0; m_err = 1'b0;
   endtask

   // Drive one clock cycle of inputs, advance the model, and return at posedge+1.
   task automatic step(input logic s_pe, input logic s_sa, input logic s_sync);
      int   ch, b, st;
      logic wr;
      pe = s_pe; sa = s_sa; sync = s_sync;
      ch = m_slot % NC;
      b  = m_slot / NC;
      st = m_st;
      m_ack = 1'b0; m_err = 1'b0;
      wr = s_pe && !s_sync && (((st == 1) && (ch == m_chan) && (b == 0)) ||
                               ((st == 2) && (ch == m_chan)));
      if (s_pe) m_gate = wr ? m_word[b] : s_sa;
      if (wr) begin
         m_st = (b == WB - 1) ? 3 : 2;
         if (b == WB - 1) m_ack = 1'b1;
      end
      if (s_sync) begin
         if (st == 1 || st == 2) begin m_st = 0; m_err = 1'b1; end
         m_slot = 0;
      end else if (s_pe) begin
         m_slot = (m_slot + 1) % NSLOT;
      end
      if (st == 0 && req) begin m_st = 1; m_chan = int'(chan); m_word = stored(data); end
      if (st == 3 && !req) m_st = 0;
      @(posedge clk); #1;
      pe = 1'b0; sync = 1'b0;
   endtask

   task automatic test_reset();
      req = 1'b1; chan = 2'd1; data = WB'($urandom);
      for (int i = 0; i < 30; i++) step(1'b1, 1'($urandom % 2), 1'b0);
      rst = 1'b1; #1;
      total++; if (gate !== 1'b0) begin bad++; $display("FAIL rst_gate got=%b exp=0", gate); end
      total++; if (ack  !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ack); end
      total++; if (err  !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (phase !== 2'd0) begin bad++; $display("FAIL rst_phase got=%0d exp=0", phase); end
      total++; if (bitc !== 5'd0) begin bad++; $display("FAIL rst_bitcnt got=%0d exp=0", bitc); end
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      total++; if (phase !== 2'd0 || bitc !== 5'd0) begin
         bad++; $display("FAIL sync_reload got=%0d/%0d exp=0/0", phase, bitc);
      end
      for (int i = 0; i < NSLOT; i++) begin
         step(1'b1, 1'($urandom % 2), 1'b0);
         total++;
         if (int'(phase) != m_slot % NC || int'(bitc) != m_slot / NC) begin
            bad++; $display("FAIL counters got=%0d/%0d exp=%0d/%0d", phase, bitc, m_slot % NC, m_slot / NC);
         end
         if ($urandom % 2 == 0) step(1'b0, 1'b0, 1'b0);
      end
      total++; if (phase !== 2'd0 || bitc !== 5'd0) begin
         bad++; $display("FAIL wrap got=%0d/%0d exp=0/0", phase, bitc);
      end
   endtask

   task automatic test_recirc();
      logic v;
      for (int i = 0; i < 2 * NSLOT; i++) begin
         v = 1'($countones(m_slot) % 2);
         step(1'b1, v, 1'b0);
         total++; if (gate !== v) begin bad++; $display("FAIL recirc slot=%0d got=%b exp=%b", i, gate, v); end
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            step(1'b0, 1'($urandom % 2), 1'b0);
            total++; if (gate !== v) begin bad++; $display("FAIL gate_hold got=%b exp=%b", gate, v); end
         end
      end
   endtask

   task automatic test_write();
      int   acks = 0;
      logic vpe;
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 37; i++) step(1'b1, 1'($urandom % 2), 1'b0);
      chan = 2'd2; data = 26'h2AAAAAA; req = 1'b1;
      for (int i = 0; i < 1500 && acks == 0; i++) begin
         vpe = ($urandom_range(0, 3) != 0);
         step(vpe, 1'($urandom % 2), 1'b0);
         total++; if (gate !== m_gate) begin bad++; $display("FAIL wr_gate slot=%0d got=%b exp=%b", m_slot, gate, m_gate); end
         total++; if (ack !== m_ack) begin bad++; $display("FAIL wr_ack got=%b exp=%b", ack, m_ack); end
         total++; if (busy !== (m_st == 1 || m_st == 2)) begin bad++; $display("FAIL wr_busy got=%b st=%0d", busy, m_st); end
         if (ack) acks++;
      end
      total++; if (acks != 1) begin bad++; $display("FAIL wr_ack_count got=%0d exp=1", acks); end
      req = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      total++; if (busy !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL wr_idle busy=%b ack=%b exp=0/0", busy, ack); end
   endtask

   task automatic test_abort();
      int acks = 0;
      chan = 2'($urandom); data = WB'($urandom); req = 1'b1;
      for (int i = 0; i < 1500 && !(m_st == 2 && m_slot / NC == 10); i++) begin
         step(($urandom_range(0, 3) != 0), 1'($urandom % 2), 1'b0);
         total++; if (gate !== m_gate) begin bad++; $display("FAIL ab_gate got=%b exp=%b", gate, m_gate); end
      end
      total++; if (!(m_st == 2 && m_slot / NC == 10)) begin bad++; $display("FAIL ab_reach timeout st=%0d", m_st); end
      req = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ab_err got=%b exp=1", err); end
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL ab_ack got=%b exp=0", ack); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy got=%b exp=0", busy); end
      step(1'b0, 1'b0, 1'b0);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL ab_err_pulse got=%b exp=0", err); end
      chan = 2'($urandom); data = WB'($urandom); req = 1'b1;
      for (int i = 0; i < 1500 && acks == 0; i++) begin
         step(($urandom_range(0, 3) != 0), 1'($urandom % 2), 1'b0);
         total++; if (gate !== m_gate) begin bad++; $display("FAIL ab2_gate got=%b exp=%b", gate, m_gate); end
         if (ack) acks++;
      end
      total++; if (acks != 1) begin bad++; $display("FAIL ab2_ack_count got=%0d exp=1", acks); end
      req = 1'b0;
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      chan = 2'($urandom); data = WB'($urandom); req = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
      chan = ~chan; data = ~data;   // second request content, must be ignored
      for (int i = 0; i < 420; i++) begin
         step(($urandom_range(0, 4) != 0), 1'($urandom % 2), 1'b0);
         total++; if (gate !== m_gate) begin bad++; $display("FAIL b2b_gate got=%b exp=%b", gate, m_gate); end
         total++; if (ack !== m_ack) begin bad++; $display("FAIL b2b_ack got=%b exp=%b", ack, m_ack); end
         if (ack) acks++;
      end
      total++; if (acks != 1) begin bad++; $display("FAIL b2b_ack_count got=%0d exp=1", acks); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_held got=%b exp=0", busy); end
      req = 1'b0;
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_parity();
      logic [WB-1:0] d [2];
      logic          e [2];
      int            acks;
`ifdef DLW_PARITY_EN
      d[0] = 26'h0000001; e[0] = 1'b0;
      d[1] = 26'h0000000; e[1] = 1'b1;
`else
      d[0] = 26'h2000000; e[0] = 1'b1;
      d[1] = 26'h0000001; e[1] = 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
         acks = 0;
         chan = 2'($urandom); data = d[k]; req = 1'b1;
         for (int i = 0; i < 1500 && acks == 0; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom % 2), 1'b0);
            total++; if (gate !== m_gate) begin bad++; $display("FAIL par_gate got=%b exp=%b", gate, m_gate); end
            if (ack) begin acks++; last_ack_gate = gate; end
         end
         total++; if (acks != 1) begin bad++; $display("FAIL par_ack_count case=%0d got=%0d exp=1", k, acks); end
         total++; if (last_ack_gate !== e[k]) begin
            bad++; $display("FAIL par_bit25 case=%0d got=%b exp=%b", k, last_ack_gate, e[k]);
         end
         req = 1'b0;
         step(1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1; pe = 1'b0; sync = 1'b0; sa = 1'b0; req = 1'b0;
      chan = 2'd0; data = '0; last_ack_gate = 1'bx; m_chan = 0; m_word = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_recirc();
      test_write();
      test_abort();
      test_back_to_back();
      test_parity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
